stream_upsizer: RTL and testbench

Parametrised width up-converter for the Ethernet datapath. It packs narrow beats (dibits from the RMII side by default) into wide words, and it adds three things the plain dibit-to-byte packer lacks:
- valid/ready backpressure on both sides
- selectable lane order
- end-of-frame flush of a partial word, with a lane count
It sits between the PHY-side dibit stream and byte- or word-wide consumers (the crypto core and the FIFOs).

---
 rtl/stream_pkg.sv | 26 ++
 rtl/stream_out_slot.sv | 40 ++++
 rtl/stream_upsizer.sv | 103 ++++++++++
 tb/tb_stream_upsizer.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stream_pkg.sv
// Shared helpers and default constants for the stream width converters.
package stream_pkg;

    localparam int DEFAULT_IN_WIDTH = 2;
    localparam int BYTE_LEN         = 8;

    // Number of bits needed to encode values 0..value-1 (0 for value <= 1).
    function automatic int clog2(input int value);
        int result;
        int remaining;
        result    = 0;
        remaining = value - 1;
        while (remaining > 0) begin
            result    = result + 1;
            remaining = remaining >> 1;
        end
        return result;
    endfunction

    // Physical lane position of the lane-th beat of a word.
    // With msb_first set, the first beat lands in the top lane.
    function automatic int mirror_lane(input int lane, input int ratio, input int msb_first);
        return (msb_first != 0) ? (ratio - 1 - lane) : lane;
    endfunction

endpackage

// File: rtl/stream_out_slot.sv
// Single-entry registered valid/ready output stage carrying {data, last, lanes}.
module stream_out_slot #(
    parameter int DATA_W = 8,
    parameter int LANE_W = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [DATA_W-1:0] load_data,
    input  logic              load_last,
    input  logic [LANE_W-1:0] load_lanes,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    output logic              out_last,
    output logic [LANE_W-1:0] out_lanes,
    input  logic              out_ready,
    output logic              slot_free
);

    // The slot can take a new word if it is empty or its word leaves this cycle.
    assign slot_free = !out_valid || out_ready;

    // Load a new word, otherwise drop valid once consumed; payload holds its value.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_data  <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_lanes <= '0;
        end else if (load) begin
            out_data  <= load_data;
            out_valid <= 1'b1;
            out_last  <= load_last;
            out_lanes <= load_lanes;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/stream_upsizer.sv
// Packs narrow input beats into wide words with backpressure, lane order
// selection and end-of-frame flush of partial words.
module stream_upsizer
    import stream_pkg::*;
#(
    parameter int IN_WIDTH  = DEFAULT_IN_WIDTH,
    parameter int RATIO     = 4,
    parameter int MSB_FIRST = 0,
    localparam int LANE_W   = clog2(RATIO + 1)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [IN_WIDTH-1:0]       in_data,
    input  logic                      in_valid,
    input  logic                      in_last,
    output logic                      in_ready,
    output logic [IN_WIDTH*RATIO-1:0] out_data,
    output logic                      out_valid,
    output logic                      out_last,
    output logic [LANE_W-1:0]         out_lanes,
    input  logic                      out_ready
);

    localparam int CNT_W  = clog2(RATIO);
    localparam int DATA_W = IN_WIDTH * RATIO;

    logic [CNT_W-1:0]    cnt;
    logic [IN_WIDTH-1:0] acc [RATIO-1];
    logic                slot_free;
    logic                closing;
    logic                accept;
    logic                load;
    logic [DATA_W-1:0]   packed_word;
    logic [LANE_W-1:0]   fill_lanes;

    assign closing    = (cnt == CNT_W'(RATIO - 1)) || in_last;
    assign in_ready   = slot_free || !closing;
    assign accept     = in_valid && in_ready;
    assign load       = accept && closing;
    assign fill_lanes = LANE_W'(int'(cnt) + 1);

    // Beat counter: advances per accepted beat, wraps explicitly on a closing beat.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (accept) begin
            if (closing) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

    // Accumulator keeps beats in arrival order; it is emptied when a word closes.
    always_ff @(posedge clk) begin
        if (reset || load) begin
            for (int i = 0; i < RATIO - 1; i++) begin
                acc[i] <= '0;
            end
        end else if (accept) begin
            for (int i = 0; i < RATIO - 1; i++) begin
                if (int'(cnt) == i) begin
                    acc[i] <= in_data;
                end
            end
        end
    end

    // Assemble the outgoing word: stored beats, the closing beat, zeros above it.
    always_comb begin
        packed_word = '0;
        for (int i = 0; i < RATIO - 1; i++) begin
            if (i < int'(cnt)) begin
                packed_word[mirror_lane(i, RATIO, MSB_FIRST)*IN_WIDTH +: IN_WIDTH] = acc[i];
            end else if (i == int'(cnt)) begin
                packed_word[mirror_lane(i, RATIO, MSB_FIRST)*IN_WIDTH +: IN_WIDTH] = in_data;
            end
        end
        if (int'(cnt) == RATIO - 1) begin
            packed_word[mirror_lane(RATIO - 1, RATIO, MSB_FIRST)*IN_WIDTH +: IN_WIDTH] = in_data;
        end
    end

    stream_out_slot #(
        .DATA_W (DATA_W),
        .LANE_W (LANE_W)
    ) u_slot (
        .clk        (clk),
        .reset      (reset),
        .load       (load),
        .load_data  (packed_word),
        .load_last  (in_last),
        .load_lanes (fill_lanes),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_last   (out_last),
        .out_lanes  (out_lanes),
        .out_ready  (out_ready),
        .slot_free  (slot_free)
    );

endmodule

// File: tb/tb_stream_upsizer.sv
// Bench for stream_upsizer: three configurations (default LSB order,
// MSB-first, 4-bit x 3), a vector table plus hand-written multi-cycle
// sequences, with a scoreboard of expected words per instance.
module tb_stream_upsizer;

    typedef struct {
        logic [31:0] data;
        int          lanes;
        logic        last;
    } exp_t;

    typedef struct {
        int          inst;
        int          n;
        logic [15:0] beats;
        logic        last;
        logic [31:0] data;
        int          lanes;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  in_data;
    logic        in_last;
    logic        out_ready;
    logic [2:0]  iv;
    logic [2:0]  ir;
    logic [2:0]  ov;
    logic [2:0]  olast;
    logic [7:0]  od_a;
    logic [7:0]  od_b;
    logic [11:0] od_c;
    logic [2:0]  ol_a;
    logic [2:0]  ol_b;
    logic [1:0]  ol_c;

    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   stall_cycles = 0;
    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];
    int   hs0[$];
    vec_t vecs[10];

    // Free-running clock, period 10.
    always #5 clk = ~clk;

    // Cycle count used to time handshakes.
    always @(posedge clk) cyc <= cyc + 1;

    stream_upsizer #(.IN_WIDTH(2), .RATIO(4), .MSB_FIRST(0)) dut_a (
        .clk(clk), .reset(reset), .in_data(in_data[1:0]), .in_valid(iv[0]), .in_last(in_last),
        .in_ready(ir[0]), .out_data(od_a), .out_valid(ov[0]), .out_last(olast[0]),
        .out_lanes(ol_a), .out_ready(out_ready));

    stream_upsizer #(.IN_WIDTH(2), .RATIO(4), .MSB_FIRST(1)) dut_b (
        .clk(clk), .reset(reset), .in_data(in_data[1:0]), .in_valid(iv[1]), .in_last(in_last),
        .in_ready(ir[1]), .out_data(od_b), .out_valid(ov[1]), .out_last(olast[1]),
        .out_lanes(ol_b), .out_ready(out_ready));

    stream_upsizer #(.IN_WIDTH(4), .RATIO(3), .MSB_FIRST(0)) dut_c (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(iv[2]), .in_last(in_last),
        .in_ready(ir[2]), .out_data(od_c), .out_valid(ov[2]), .out_last(olast[2]),
        .out_lanes(ol_c), .out_ready(out_ready));

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("[TB] FAIL %s: got=%0h want=%0h", name, got, want);
        end
    endtask

    task automatic pushExp(input int k, input logic [31:0] d, input int lanes, input logic l);
        exp_t e;
        e.data  = d;
        e.lanes = lanes;
        e.last  = l;
        case (k)
            0:       q0.push_back(e);
            1:       q1.push_back(e);
            default: q2.push_back(e);
        endcase
    endtask

    task automatic checkOutput(input int k, input logic [31:0] d, input int lanes, input logic l);
        exp_t e;
        int   n;
        n = (k == 0) ? q0.size() : (k == 1) ? q1.size() : q2.size();
        if (n == 0) begin
            total++;
            bad++;
            $display("[TB] FAIL inst%0d unexpected word: got data=%0h lanes=%0d, want none", k, d, lanes);
            return;
        end
        case (k)
            0:       e = q0.pop_front();
            1:       e = q1.pop_front();
            default: e = q2.pop_front();
        endcase
        check($sformatf("inst%0d data", k), d, e.data);
        check($sformatf("inst%0d lanes", k), 32'(lanes), 32'(e.lanes));
        check($sformatf("inst%0d last", k), 32'(l), 32'(e.last));
    endtask

    // Output monitor: samples one time unit before each rising edge.
    always begin
        @(negedge clk);
        #4;
        if (!reset) begin
            if (ov[0] && out_ready) begin
                hs0.push_back(cyc);
                checkOutput(0, 32'(od_a), int'(ol_a), olast[0]);
            end
            if (ov[1] && out_ready) checkOutput(1, 32'(od_b), int'(ol_b), olast[1]);
            if (ov[2] && out_ready) checkOutput(2, 32'(od_c), int'(ol_c), olast[2]);
        end
    end

    // Called at a falling edge; returns at the falling edge after acceptance.
    task automatic applyStimulus(input int k, input logic [3:0] d, input logic l);
        int waited;
        waited  = 0;
        in_data = d;
        in_last = l;
        iv[k]   = 1'b1;
        #1;
        while (!ir[k] && waited < 100) begin
            stall_cycles++;
            @(negedge clk);
            #1;
            waited++;
        end
        if (!ir[k]) begin
            total++;
            bad++;
            $display("[TB] FAIL inst%0d in_ready timeout: got=0 want=1", k);
            iv[k] = 1'b0;
        end
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        iv = '0;
        repeat (n) @(negedge clk);
    endtask

    task automatic waitDrain();
        int waited;
        waited = 0;
        while ((q0.size() + q1.size() + q2.size()) != 0 && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        check("scoreboard drained", 32'(q0.size() + q1.size() + q2.size()), 32'd0);
        repeat (2) @(negedge clk);
    endtask

    // Global watchdog so the run always ends.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [15:0] bt;
        logic [7:0]  held;
        logic        saw_block;
        logic        stable;
        int          w;

        reset = 1'b1;
        iv = '0;
        in_data = '0;
        in_last = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check("reset out_data", 32'(od_a), 32'd0);
        check("reset out_valid", 32'(ov), 32'd0);
        check("reset out_last", 32'(olast), 32'd0);
        check("reset out_lanes", 32'(ol_a), 32'd0);
        check("reset nibble out_data", 32'(od_c), 32'd0);
        check("reset in_ready", 32'(ir), 32'h7);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // inst, beats, beat nibbles (beat0 lowest), last on final beat, expected word, lanes
        vecs[0] = '{0, 4, 16'h0321, 1'b1, 32'h39,  4};
        vecs[1] = '{1, 4, 16'h0321, 1'b1, 32'h6C,  4};
        vecs[2] = '{0, 2, 16'h0013, 1'b1, 32'h07,  2};
        vecs[3] = '{0, 1, 16'h0002, 1'b1, 32'h02,  1};
        vecs[4] = '{1, 2, 16'h0013, 1'b1, 32'hD0,  2};
        vecs[5] = '{2, 3, 16'h0321, 1'b0, 32'h321, 3};
        vecs[6] = '{0, 4, 16'h3102, 1'b0, 32'hD2,  4};
        vecs[7] = '{2, 1, 16'h000A, 1'b1, 32'h00A, 1};
        vecs[8] = '{1, 1, 16'h0002, 1'b1, 32'h80,  1};
        vecs[9] = '{2, 2, 16'h00F5, 1'b1, 32'h0F5, 2};

        for (int i = 0; i < 10; i++) begin
            bt = vecs[i].beats;
            for (int b = 0; b < vecs[i].n; b++) begin
                if (b == vecs[i].n - 1) begin
                    pushExp(vecs[i].inst, vecs[i].data, vecs[i].lanes, vecs[i].last);
                    applyStimulus(vecs[i].inst, bt[b*4 +: 4], vecs[i].last);
                end else begin
                    applyStimulus(vecs[i].inst, bt[b*4 +: 4], 1'b0);
                end
            end
            idle(3);
        end
        waitDrain();

        // Reset part-way through a word discards the partial beats.
        applyStimulus(0, 4'd0, 1'b0);
        applyStimulus(0, 4'd1, 1'b0);
        iv = '0;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        check("mid-word reset out_valid", 32'(ov[0]), 32'd0);
        reset = 1'b0;
        @(negedge clk);
        pushExp(0, 32'hFF, 4, 1'b0);
        for (int b = 0; b < 4; b++) applyStimulus(0, 4'd3, 1'b0);
        idle(3);
        waitDrain();

        // Backpressure: 16 beats 0,1,2,3 repeating while the first word is held.
        out_ready = 1'b0;
        hs0.delete();
        saw_block = 1'b0;
        stable = 1'b1;
        fork
            begin
                for (int i = 0; i < 16; i++) begin
                    if (i % 4 == 3) pushExp(0, 32'hE4, 4, 1'b0);
                    applyStimulus(0, 4'(i % 4), 1'b0);
                end
                iv[0] = 1'b0;
            end
            begin
                w = 0;
                while (!ov[0] && w < 100) begin
                    @(negedge clk);
                    w++;
                end
                held = od_a;
                repeat (5) begin
                    @(negedge clk);
                    #1;
                    if (iv[0] && !ir[0]) saw_block = 1'b1;
                    if (od_a != held || !ov[0]) stable = 1'b0;
                end
                @(negedge clk);
                out_ready = 1'b1;
            end
        join
        idle(3);
        waitDrain();
        check("backpressure in_ready dropped", 32'(saw_block), 32'd1);
        check("backpressure word held", 32'(stable), 32'd1);
        check("backpressure held word value", 32'(held), 32'hE4);
        check("backpressure word count", 32'(hs0.size()), 32'd4);

        // Streaming: 8 back-to-back beats with the output always ready.
        hs0.delete();
        stall_cycles = 0;
        for (int i = 0; i < 8; i++) begin
            if (i % 4 == 3) pushExp(0, 32'hE4, 4, 1'b0);
            applyStimulus(0, 4'(i % 4), 1'b0);
        end
        idle(3);
        waitDrain();
        check("streaming stall cycles", 32'(stall_cycles), 32'd0);
        check("streaming word count", 32'(hs0.size()), 32'd2);
        if (hs0.size() >= 2) check("streaming word spacing", 32'(hs0[1] - hs0[0]), 32'd4);

        // Consume and reload in the same cycle: single-beat frames back-to-back.
        hs0.delete();
        for (int i = 1; i <= 3; i++) begin
            pushExp(0, 32'(i), 1, 1'b1);
            applyStimulus(0, 4'(i), 1'b1);
        end
        idle(3);
        waitDrain();
        check("reload word count", 32'(hs0.size()), 32'd3);
        if (hs0.size() >= 3) begin
            check("reload spacing 1", 32'(hs0[1] - hs0[0]), 32'd1);
            check("reload spacing 2", 32'(hs0[2] - hs0[1]), 32'd1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
